// File: rtl/stream_fifo.sv
// stream_fifo: parametrised synchronous FIFO with standard or first-word-fall-through read
// Ports: clk; reset (sync, active-high); flush (sync clear of contents)
//        write side: wr_en, wr_data, full, almost_full
//        read side:  rd_en, rd_data, rd_valid, empty, almost_empty
//        status:     count (occupancy 0..DEPTH), sticky overflow/underflow, clr_err
module stream_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);
   localparam int                DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
   logic                  wr_ok, rd_ok, ov_set, un_set, mem_empty, load, rd_adv;
   // In FWFT mode the head word lives in rd_data, so the FIFO is empty only when that register is.
   always_comb begin
      full         = count == DEPTH_C;
      empty        = FWFT != 0 ? !rd_valid : count == '0;
      almost_full  = count >= AF_C;
      almost_empty = count <= AE_C;
      wr_ok        = wr_en && !full && !flush;
      rd_ok        = rd_en && !empty && !flush;
      ov_set       = wr_en && full && !flush;
      un_set       = rd_en && empty && !flush;
      mem_empty    = wr_ptr == rd_ptr;
      load         = !mem_empty && (!rd_valid || rd_ok);
      rd_adv       = FWFT != 0 ? load : rd_ok;
   end
   always_ff @(posedge clk)
      if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ov_set || (overflow && !clr_err);
         underflow <= un_set || (underflow && !clr_err);
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) begin
               rd_ptr  <= rd_ptr + 1'b1;
               rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            // FWFT: the output register stays full unless popped with nothing left to prefetch.
            rd_valid <= FWFT != 0 ? (load || (rd_valid && !rd_ok)) : rd_ok;
            count    <= count + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
         end
      end
   end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed checks of stream_fifo in standard and FWFT read modes
module tb_stream_fifo;
   logic clk = 1'b0;
   logic reset, flush, wr_en, rd_en, clr_err;
   logic [7:0] wr_data;
   logic full0, af0, rv0, empty0, ae0, ov0, un0;
   logic full1, af1, rv1, empty1, ae1, ov1, un1;
   logic [7:0] rd_data0, rd_data1;
   logic [4:0] count0, count1;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   stream_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) d0 (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .full(full0), .almost_full(af0), .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rv0),
      .empty(empty0), .almost_empty(ae0), .count(count0), .overflow(ov0), .underflow(un0),
      .clr_err(clr_err));
   stream_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) d1 (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .full(full1), .almost_full(af1), .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rv1),
      .empty(empty1), .almost_empty(ae1), .count(count1), .overflow(ov1), .underflow(un1),
      .clr_err(clr_err));
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask
   task automatic check_reset;
      check("rst count0", 32'(count0), 0);
      check("rst empty0", 32'(empty0), 1);
      check("rst full0", 32'(full0), 0);
      check("rst ae0", 32'(ae0), 1);
      check("rst af0", 32'(af0), 0);
      check("rst rd_data0", 32'(rd_data0), 0);
      check("rst rv0", 32'(rv0), 0);
      check("rst ov0", 32'(ov0), 0);
      check("rst un0", 32'(un0), 0);
      check("rst count1", 32'(count1), 0);
      check("rst empty1", 32'(empty1), 1);
      check("rst rv1", 32'(rv1), 0);
      check("rst ov1", 32'(ov1), 0);
   endtask
   initial begin
      reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
      do_reset();
      check_reset();
      // standard mode fill and drain
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
         check("fill count", 32'(count0), 32'(i + 1));
         check("fill af", 32'(af0), 32'(i + 1 >= 14));
         check("fill ae", 32'(ae0), 32'(i == 0));
         check("fill full", 32'(full0), 32'(i == 15));
      end
      wr_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         check("drain rv", 32'(rv0), 1);
         check("drain data", 32'(rd_data0), 32'(i));
         check("drain count", 32'(count0), 32'(15 - i));
      end
      rd_en = 1'b0;
      step();
      check("drain rv pulse", 32'(rv0), 0);
      check("drain empty", 32'(empty0), 1);
      // overflow with simultaneous read, then clear, then underflow
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h10 + i);
         step();
      end
      check("refill full", 32'(full0), 1);
      wr_data = 8'hAA; rd_en = 1'b1;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      check("ovf flag", 32'(ov0), 1);
      check("ovf count", 32'(count0), 15);
      check("ovf rd_data", 32'(rd_data0), 32'h10);
      check("ovf full", 32'(full0), 0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr ovf", 32'(ov0), 0);
      for (int i = 0; i < 15; i++) begin
         rd_en = 1'b1;
         step();
         check("post ovf data", 32'(rd_data0), 32'(8'h11 + i));
      end
      check("post ovf empty", 32'(empty0), 1);
      step();
      rd_en = 1'b0;
      check("unf flag", 32'(un0), 1);
      check("unf rd_data", 32'(rd_data0), 32'h1F);
      check("unf rv", 32'(rv0), 0);
      check("unf no ovf", 32'(ov0), 0);
      // FWFT latency
      do_reset();
      wr_en = 1'b1; wr_data = 8'h5A;
      step();
      wr_en = 1'b0;
      check("fwft k rv", 32'(rv1), 0);
      check("fwft k count", 32'(count1), 1);
      step();
      check("fwft k+1 rv", 32'(rv1), 1);
      check("fwft k+1 data", 32'(rd_data1), 32'h5A);
      check("fwft k+1 count", 32'(count1), 1);
      check("fwft k+1 empty", 32'(empty1), 0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("fwft pop rv", 32'(rv1), 0);
      check("fwft pop empty", 32'(empty1), 1);
      check("fwft pop count", 32'(count1), 0);
      // FWFT back-to-back pops
      for (int i = 1; i <= 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      check("fwft head", 32'(rd_data1), 1);
      check("fwft head count", 32'(count1), 3);
      rd_en = 1'b1;
      for (int i = 2; i <= 3; i++) begin
         step();
         check("fwft b2b rv", 32'(rv1), 1);
         check("fwft b2b data", 32'(rd_data1), 32'(i));
         check("fwft b2b count", 32'(count1), 32'(4 - i));
      end
      step();
      rd_en = 1'b0;
      check("fwft b2b end rv", 32'(rv1), 0);
      check("fwft b2b end count", 32'(count1), 0);
      check("fwft no unf", 32'(un1), 0);
      // pointer wrap with steady count of 3 in both modes
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      check("wrap pre head1", 32'(rd_data1), 0);
      for (int i = 0; i < 40; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(3 + i);
         step();
         check("wrap data0", 32'(rd_data0), 32'(i));
         check("wrap count0", 32'(count0), 3);
         check("wrap data1", 32'(rd_data1), 32'(i + 1));
         check("wrap count1", 32'(count1), 3);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      check("wrap no err", 32'({ov0, un0, ov1, un1}), 0);
      // flush mid-stream
      do_reset();
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h30 + i);
         step();
      end
      check("flush pre count0", 32'(count0), 9);
      check("flush pre count1", 32'(count1), 9);
      flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      step();
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      check("flush count0", 32'(count0), 0);
      check("flush empty0", 32'(empty0), 1);
      check("flush rv0", 32'(rv0), 0);
      check("flush err0", 32'({ov0, un0}), 0);
      check("flush rd_data0", 32'(rd_data0), 0);
      check("flush count1", 32'(count1), 0);
      check("flush empty1", 32'(empty1), 1);
      check("flush rv1", 32'(rv1), 0);
      check("flush err1", 32'({ov1, un1}), 0);
      check("flush rd_data1", 32'(rd_data1), 32'h30);
      wr_en = 1'b1; wr_data = 8'h77;
      step();
      wr_en = 1'b0;
      step();
      check("post flush data1", 32'(rd_data1), 32'h77);
      check("post flush rv1", 32'(rv1), 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("post flush data0", 32'(rd_data0), 32'h77);
      check("post flush rv0", 32'(rv0), 1);
      // reset mid-operation, with overflow raised in a clr_err cycle
      do_reset();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0; wr_en = 1'b0;
      check("ovf set wins", 32'(ov0), 1);
      for (int i = 0; i < 9; i++) begin
         rd_en = 1'b1;
         step();
      end
      rd_en = 1'b0;
      check("mid count0", 32'(count0), 7);
      check("mid ov0", 32'(ov0), 1);
      do_reset();
      check_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous FIFO that succeeds the UART/SPI/I2C byte FIFO.
- Adds a selectable read mode: standard registered read (FWFT=0) or first-word-fall-through (FWFT=1).
- Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between the CPU register interface and the serial protocol cores, as TX/RX buffering for all three.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- full  out  1  no space for a write.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request (FWFT=0) or pop/acknowledge (FWFT=1).
- rd_data  out  DATA_WIDTH  read word (registered in both modes).
- rd_valid  out  1  FWFT=0: one-cycle pulse, rd_data valid. FWFT=1: level, rd_data holds the head word.
- empty  out  1  no word available to read.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (priority over all other inputs) forces: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory array is not reset.
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH; the MSB disambiguates full from empty. Address = low ADDR_WIDTH bits.
- Write acceptance: wr_en && !full, using flag values before the edge. An accepted write stores wr_data and increments count.
- Rejected write (wr_en && full): data dropped, overflow set. This holds even if a read is accepted in the same cycle, because full is evaluated before the edge.
- Read acceptance: rd_en && !empty. A rejected read (rd_en && empty) sets underflow and leaves rd_data unchanged.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- count, full, empty, almost_full and almost_empty are all registered or decoded from registered state; no combinational path from wr_en/rd_en to any flag.
- FWFT=0 read path:
  - Accepted read at edge k: rd_data = head word and rd_valid=1 after edge k; rd_valid=0 the following cycle unless another read is accepted.
  - empty = (count==0).
  - A write accepted at edge k clears empty after edge k.
- FWFT=1 read path:
  - An internal prefetch moves the head word from memory into the rd_data register whenever that register is empty or is being popped.
  - rd_valid=1 while the register holds a word; empty = !rd_valid.
  - A write into an empty FIFO accepted at edge k gives rd_valid=1 and rd_data=word after edge k+1.
  - An accepted pop with a further word in memory keeps rd_valid=1 and presents the next word after the same edge (back-to-back pops sustain 1 word/cycle).
  - The word in the output register counts toward count; total capacity is DEPTH in both modes.
- flush (below reset, above wr/rd):
  - Clears pointers and count, sets empty=1 and full=0, sets rd_valid=0.
  - wr_en and rd_en in a flush cycle are ignored and raise no error.
  - rd_data holds its value; sticky flags are unchanged.
- clr_err clears both sticky flags. If an error occurs in the same cycle as clr_err, the flag is set (set wins).

Test Plan:
- FWFT=0, DATA_WIDTH=8, ADDR_WIDTH=4, fill:
  - Write 0x00..0x0F on 16 consecutive cycles -> count steps 1..16; almost_full rises after the 14th write; full=1 after the 16th.
  - Read 16 times -> rd_valid pulses, rd_data 0x00..0x0F in order, empty=1 after the last.
- Overflow and clear:
  - Full FIFO, wr_en=1 with 0xAA while rd_en=1 -> 0xAA dropped, overflow=1, count=15.
  - clr_err -> overflow=0.
  - underflow path: rd_en on empty -> underflow=1, rd_data unchanged.
- FWFT=1 latency:
  - Write 0x5A to an empty FIFO at edge k -> rd_valid=1, rd_data=0x5A after edge k+1, count=1.
  - Hold rd_en=1 over a stream of 0x01,0x02,0x03 -> one word per cycle; rd_valid drops after 0x03 is popped.
- Pointer wrap: 40 cycles of simultaneous write/read of an incrementing pattern, started at count=3 -> count stays 3; output sequence is gap-free across both pointer wraps.
- flush mid-stream: count=9 with wr_en=1 and rd_en=1 in the flush cycle -> count=0, empty=1, rd_valid=0, no error flags; next write is read back first.
- Reset mid-operation: assert reset with count=7 and overflow=1 -> all outputs at their reset values on the next cycle.
